// File: rtl/portarb.sv
// N-way request arbiter (fixed priority or round-robin) with per-requester lock; grant is same-cycle combinational.
// addr/data/gidx/vld register the granted transfer one cycle later; no backpressure, a grant always completes.
module portarb #(
    parameter int N  = 3,
    parameter int a  = 9,
    parameter int w  = 128,
    parameter int RR = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           csel,
    input  logic [N-1:0]           lock,
    input  logic [N*a-1:0]         addrIn,
    input  logic [N*w-1:0]         dataIn,
    output logic [N-1:0]           grnt,
    output logic [a-1:0]           addr,
    output logic [w-1:0]           data,
    output logic                   vld,
    output logic [$clog2(N)-1:0]   gidx
);
    localparam int IW = $clog2(N);

    logic          locked;
    logic [IW-1:0] owner;
    logic [IW-1:0] ptr;
    logic          hit;
    logic [IW-1:0] gsel;

    always_comb begin
        grnt = '0;
        hit  = 1'b0;
        gsel = '0;
        if (!rst) begin
            if (locked && csel[owner]) begin
                hit  = 1'b1;
                gsel = owner;
            end else if (RR == 0) begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (csel[i]) begin
                        hit  = 1'b1;
                        gsel = IW'(i);
                    end
                end
            end else begin
                // descending scan so the requester nearest ptr wins
                for (int k = N - 1; k >= 0; k--) begin
                    if (csel[(int'(ptr) + k) % N]) begin
                        hit  = 1'b1;
                        gsel = IW'((int'(ptr) + k) % N);
                    end
                end
            end
            if (hit) begin
                grnt[gsel] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld    <= 1'b0;
            addr   <= '0;
            data   <= '0;
            gidx   <= '0;
            ptr    <= '0;
            locked <= 1'b0;
            owner  <= '0;
        end else begin
            vld    <= hit;
            locked <= hit && lock[gsel];
            if (hit) begin
                addr <= addrIn[int'(gsel)*a +: a];
                data <= dataIn[int'(gsel)*w +: w];
                gidx <= gsel;
            end
            if (hit && lock[gsel]) begin
                owner <= gsel;
            end
            // pointer moves only once the transfer is no longer held by a lock
            if (RR != 0 && hit && !lock[gsel]) begin
                ptr <= (int'(gsel) == N - 1) ? '0 : gsel + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_portarb.sv
// Directed bench for portarb: one fixed-priority and one round-robin instance, scoreboard of registered outputs.
module tb_portarb;
    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   csel0, lock0, csel1, lock1;
    logic [26:0]  addr_in;
    logic [383:0] data_in;
    logic [2:0]   grnt0, grnt1;
    logic [8:0]   addr0, addr1;
    logic [127:0] data0, data1;
    logic         vld0, vld1;
    logic [1:0]   gidx0, gidx1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic         v;
        logic [1:0]   g;
        logic [8:0]   a;
        logic [127:0] d;
    } exp_t;

    exp_t         q0[$];
    exp_t         q1[$];
    logic [1:0]   hg[2];
    logic [8:0]   ha[2];
    logic [127:0] hd[2];

    always #5 clk = ~clk;

    portarb #(.N(3), .a(9), .w(128), .RR(0)) u_fp (
        .clk(clk), .rst(rst), .csel(csel0), .lock(lock0),
        .addrIn(addr_in), .dataIn(data_in),
        .grnt(grnt0), .addr(addr0), .data(data0), .vld(vld0), .gidx(gidx0)
    );

    portarb #(.N(3), .a(9), .w(128), .RR(1)) u_rr (
        .clk(clk), .rst(rst), .csel(csel1), .lock(lock1),
        .addrIn(addr_in), .dataIn(data_in),
        .grnt(grnt1), .addr(addr1), .data(data1), .vld(vld1), .gidx(gidx1)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            hg[d] = '0;
            ha[d] = '0;
            hd[d] = '0;
        end
    endtask

    // Drive one cycle on instance d, check the combinational grant, then the registered result.
    task automatic step(input int d, input logic [2:0] cs, input logic [2:0] lk,
                        input logic [2:0] eg, input string tag);
        exp_t e;
        exp_t o;
        int   g;
        if (d == 0) begin
            csel0 = cs; lock0 = lk; csel1 = '0; lock1 = '0;
        end else begin
            csel1 = cs; lock1 = lk; csel0 = '0; lock0 = '0;
        end
        #1;
        chk({tag, ".grnt"}, (d == 0) ? grnt0 : grnt1, eg);
        e.v = (eg != 3'b000);
        if (e.v) begin
            g     = eg[2] ? 2 : (eg[1] ? 1 : 0);
            hg[d] = 2'(g);
            ha[d] = addr_in[g*9 +: 9];
            hd[d] = data_in[g*128 +: 128];
        end
        e.g = hg[d];
        e.a = ha[d];
        e.d = hd[d];
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk);
        #1;
        if (d == 0) begin
            o = q0.pop_front();
            chk({tag, ".vld"},  vld0,  o.v);
            chk({tag, ".gidx"}, gidx0, o.g);
            chk({tag, ".addr"}, addr0, o.a);
            chk({tag, ".data"}, data0, o.d);
        end else begin
            o = q1.pop_front();
            chk({tag, ".vld"},  vld1,  o.v);
            chk({tag, ".gidx"}, gidx1, o.g);
            chk({tag, ".addr"}, addr1, o.a);
            chk({tag, ".data"}, data1, o.d);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        csel0   = '0;
        lock0   = '0;
        csel1   = 3'b111;
        lock1   = 3'b111;
        addr_in = {9'h1C3, 9'h05A, 9'h011};
        data_in = {{4{32'hC2C2_0002}}, {4{32'hB1B1_0001}}, {4{32'hA0A0_0000}}};
        clear_model();

        // reset state, grant suppressed even with requests present
        #1;
        chk("rst.grnt", grnt1, 3'b000);
        chk("rst.vld",  vld1,  1'b0);
        chk("rst.addr", addr1, 9'h000);
        chk("rst.data", data1, 128'h0);
        chk("rst.gidx", gidx1, 2'd0);
        @(posedge clk);
        #1;
        chk("rst_edge.grnt", grnt1, 3'b000);
        chk("rst_edge.vld",  vld1,  1'b0);
        csel1 = '0;
        lock1 = '0;
        rst   = 1'b0;

        // fixed priority
        step(0, 3'b110, 3'b000, 3'b010, "fp_110");
        step(0, 3'b111, 3'b000, 3'b001, "fp_111");
        step(0, 3'b101, 3'b000, 3'b001, "fp_101");
        step(0, 3'b100, 3'b000, 3'b100, "fp_100");
        step(0, 3'b000, 3'b000, 3'b000, "fp_idle");
        step(0, 3'b110, 3'b010, 3'b010, "fp_lock_a");
        step(0, 3'b011, 3'b010, 3'b010, "fp_lock_b");
        step(0, 3'b011, 3'b000, 3'b010, "fp_lock_last");
        step(0, 3'b011, 3'b000, 3'b001, "fp_after_lock");
        step(0, 3'b110, 3'b010, 3'b010, "fp_lock_c");
        step(0, 3'b101, 3'b000, 3'b001, "fp_release");
        step(0, 3'b000, 3'b000, 3'b000, "fp_idle2");

        // round-robin rotation
        step(1, 3'b111, 3'b000, 3'b001, "rr_0");
        step(1, 3'b111, 3'b000, 3'b010, "rr_1");
        step(1, 3'b111, 3'b000, 3'b100, "rr_2");
        step(1, 3'b111, 3'b000, 3'b001, "rr_3");
        step(1, 3'b000, 3'b000, 3'b000, "rr_idle");
        step(1, 3'b101, 3'b000, 3'b100, "rr_skip");
        step(1, 3'b010, 3'b000, 3'b010, "rr_req1");
        step(1, 3'b000, 3'b000, 3'b000, "rr_hold");

        // lock held by requester 2 against competing requests
        step(1, 3'b111, 3'b100, 3'b100, "lk_1");
        step(1, 3'b111, 3'b100, 3'b100, "lk_2");
        step(1, 3'b111, 3'b100, 3'b100, "lk_3");
        step(1, 3'b111, 3'b000, 3'b100, "lk_last");
        step(1, 3'b111, 3'b000, 3'b001, "lk_next");

        // reset while requester 1 holds the lock
        step(1, 3'b010, 3'b010, 3'b010, "ml_a");
        step(1, 3'b111, 3'b010, 3'b010, "ml_b");
        rst = 1'b1;
        #1;
        chk("ml_rst.vld",  vld1,  1'b0);
        chk("ml_rst.addr", addr1, 9'h000);
        chk("ml_rst.gidx", gidx1, 2'd0);
        chk("ml_rst.data", data1, 128'h0);
        chk("ml_rst.grnt", grnt1, 3'b000);
        chk("ml_rst.fp_vld", vld0, 1'b0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        csel1 = '0;
        lock1 = '0;
        clear_model();
        step(1, 3'b011, 3'b000, 3'b001, "post_rst_unlocked");
        step(1, 3'b010, 3'b000, 3'b010, "post_rst_010");
        step(1, 3'b011, 3'b000, 3'b001, "post_rst_011");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
